// File: rtl/risc_pkg.sv
// risc_pkg: shared encodings for the 16-bit RISC control unit, datapath and benches
package risc_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;
  typedef enum logic [3:0] {
    C_ALU, C_LD, C_ST, C_BEQ, C_JMP, C_LDI, C_NOP, C_HALT, C_ILL
  } op_class_t;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hB;
  localparam logic [3:0] OP_NOP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_PASS = 3'd7;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;
endpackage

// File: rtl/risc_op_decoder.sv
// risc_op_decoder: classifies the latched opcode into the control unit's instruction classes
module risc_op_decoder import risc_pkg::*; #(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] op,
  output op_class_t      cls
);
  // Opcodes D and E are unassigned and fall through to the illegal class
  always_comb begin
    cls = C_ILL;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: cls = C_ALU;
      OP_LD:   cls = C_LD;
      OP_ST:   cls = C_ST;
      OP_BEQ:  cls = C_BEQ;
      OP_JMP:  cls = C_JMP;
      OP_LDI:  cls = C_LDI;
      OP_NOP:  cls = C_NOP;
      OP_HALT: cls = C_HALT;
      default: cls = C_ILL;
    endcase
  end
endmodule

// File: rtl/risc_control_fsm.sv
// risc_control_fsm: multi-cycle Moore control unit sequencing the 16-bit RISC datapath
module risc_control_fsm import risc_pkg::*; #(
  parameter int OPW         = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic [OPW-1:0] instr_op,
  input  logic           alu_zero,
  input  logic           mem_ack,
  output logic           pc_en,
  output logic [1:0]     pc_sel,
  output logic           ir_load,
  output logic [2:0]     alu_s,
  output logic           alu_src,
  output logic           reg_we,
  output logic [1:0]     wb_sel,
  output logic           mem_req,
  output logic           mem_we,
  output logic [2:0]     state,
  output logic [2:0]     nstate,
  output logic           halted,
  output logic           err
);
  localparam int CW = $clog2(MEM_TIMEOUT);
  state_t         st, nst, bnd;
  logic [OPW-1:0] op;
  logic [CW-1:0]  cnt;
  op_class_t      cls;
  logic           ill, tmo;
  risc_op_decoder #(.OPW(OPW)) u_dec (.op(op), .cls(cls));
  assign bnd    = run ? S_FETCH : S_IDLE;
  assign ill    = st == S_DECODE && cls == C_ILL;
  assign tmo    = st == S_MEM && !mem_ack && cnt == CW'(MEM_TIMEOUT - 1);
  assign state  = st;
  assign nstate = nst;
  // State, opcode latch, MEM wait counter and sticky fault flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st  <= S_IDLE;
      op  <= OPW'(OP_NOP);
      cnt <= '0;
      err <= 1'b0;
    end else begin
      st  <= nst;
      if (st == S_FETCH) op <= instr_op;
      cnt <= (st == S_MEM && nst == S_MEM) ? cnt + 1'b1 : '0;
      if (ill || tmo) err <= 1'b1;
    end
  end
  // Next state; every instruction ends at a boundary that only refetches while run is high
  always_comb begin
    nst = S_IDLE;
    case (st)
      S_IDLE:    nst = bnd;
      S_FETCH:   nst = S_DECODE;
      S_DECODE:  nst = cls == C_HALT ? S_HALT : (cls inside {C_JMP, C_NOP, C_ILL}) ? bnd : S_EXECUTE;
      S_EXECUTE: nst = (cls inside {C_LD, C_ST}) ? S_MEM : cls == C_BEQ ? bnd : S_WB;
      S_MEM:     nst = mem_ack ? (cls == C_LD ? S_WB : bnd) : tmo ? S_HALT : S_MEM;
      S_WB:      nst = bnd;
      S_HALT:    nst = S_HALT;
      default:   nst = S_IDLE;
    endcase
  end
  // Datapath strobes from state and latched opcode; only the BEQ branch looks at alu_zero
  always_comb begin
    pc_en   = 1'b0;
    pc_sel  = PC_INC;
    ir_load = 1'b0;
    alu_s   = ALU_ADD;
    alu_src = 1'b0;
    reg_we  = 1'b0;
    wb_sel  = WB_ALU;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;
    case (st)
      S_FETCH: begin
        ir_load = 1'b1;
        pc_en   = 1'b1;
      end
      S_DECODE: begin
        pc_en  = cls == C_JMP;
        pc_sel = cls == C_JMP ? PC_JMP : PC_INC;
      end
      S_EXECUTE: begin
        alu_src = cls inside {C_LD, C_ST, C_LDI};
        alu_s   = cls == C_ALU ? op[2:0] : cls == C_LDI ? ALU_PASS : cls == C_BEQ ? ALU_SUB : ALU_ADD;
        pc_en   = cls == C_BEQ && alu_zero;
        pc_sel  = (cls == C_BEQ && alu_zero) ? PC_BR : PC_INC;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = cls == C_ST;
      end
      S_WB: begin
        reg_we = 1'b1;
        wb_sel = cls == C_LD ? WB_MEM : cls == C_LDI ? WB_IMM : WB_ALU;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_risc_control_fsm.sv
// tb_risc_control_fsm: directed scoreboard bench for the RISC control unit
module tb_risc_control_fsm;
  import risc_pkg::*;
  logic clk = 1'b0, reset, run, alu_zero, mem_ack;
  logic [3:0] instr_op;
  logic pc_en, ir_load, alu_src, reg_we, mem_req, mem_we, halted, err;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] alu_s, state, nstate;
  logic [17:0] obs;
  int errors = 0, checks = 0;
  typedef struct { string tag; logic [17:0] v; } exp_t;
  exp_t q[$];
  risc_control_fsm #(.OPW(4), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .run(run), .instr_op(instr_op), .alu_zero(alu_zero),
    .mem_ack(mem_ack), .pc_en(pc_en), .pc_sel(pc_sel), .ir_load(ir_load), .alu_s(alu_s),
    .alu_src(alu_src), .reg_we(reg_we), .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we),
    .state(state), .nstate(nstate), .halted(halted), .err(err)
  );
  always #5 clk = ~clk;
  assign obs = {state, pc_en, pc_sel, ir_load, alu_s, alu_src, reg_we, wb_sel, mem_req, mem_we, halted, err};
  function automatic logic [17:0] vec(input logic [2:0] s, input logic pe, input logic [1:0] ps,
      input logic il, input logic [2:0] as, input logic src, input logic we, input logic [1:0] wb,
      input logic mr, input logic mw, input logic h, input logic e);
    return {s, pe, ps, il, as, src, we, wb, mr, mw, h, e};
  endfunction
  function automatic logic [17:0] idle_v(input logic e);
    return vec(3'd0, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 0, 0, 0, e);
  endfunction
  function automatic logic [17:0] fetch_v(input logic e);
    return vec(3'd1, 1, 2'd0, 1, 3'd0, 0, 0, 2'd0, 0, 0, 0, e);
  endfunction
  function automatic logic [17:0] dec_v(input logic e);
    return vec(3'd2, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 0, 0, 0, e);
  endfunction
  task automatic push(input string tag, input logic [17:0] v);
    exp_t x;
    x.tag = tag;
    x.v = v;
    q.push_back(x);
  endtask
  task automatic chk();
    exp_t x;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%b expected=<entry>", obs);
      return;
    end
    x = q.pop_front();
    assert (obs === x.v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", x.tag, obs, x.v);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk();
    end
  endtask
  initial begin
    reset = 1'b0; run = 1'b1; instr_op = OP_ADD; alu_zero = 1'b0; mem_ack = 1'b0;
    push("rst_c0", idle_v(0)); push("rst_c1", idle_v(0));
    ticks(2);
    reset = 1'b1;
    #1;
    checks++;
    assert (nstate === 3'd1) else begin
      errors++;
      $error("FAIL nstate_idle_run: observed=%0d expected=1", nstate);
    end
    push("add_fetch", fetch_v(0)); push("add_dec", dec_v(0));
    push("add_ex", vec(3'd3, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 0, 0, 0, 0));
    push("add_wb", vec(3'd5, 0, 2'd0, 0, 3'd0, 0, 1, 2'd0, 0, 0, 0, 0));
    ticks(4);
    instr_op = OP_XOR;
    push("xor_fetch", fetch_v(0)); push("xor_dec", dec_v(0));
    push("xor_ex", vec(3'd3, 0, 2'd0, 0, 3'd4, 0, 0, 2'd0, 0, 0, 0, 0));
    push("xor_wb", vec(3'd5, 0, 2'd0, 0, 3'd0, 0, 1, 2'd0, 0, 0, 0, 0));
    ticks(4);
    instr_op = OP_LD;
    push("ld_fetch", fetch_v(0)); push("ld_dec", dec_v(0));
    push("ld_ex", vec(3'd3, 0, 2'd0, 0, 3'd0, 1, 0, 2'd0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) push($sformatf("ld_mem%0d", i), vec(3'd4, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 1, 0, 0, 0));
    ticks(6);
    mem_ack = 1'b1;
    push("ld_wb", vec(3'd5, 0, 2'd0, 0, 3'd0, 0, 1, 2'd1, 0, 0, 0, 0));
    ticks(1);
    mem_ack = 1'b0;
    instr_op = OP_LDI;
    push("ldi_fetch", fetch_v(0)); push("ldi_dec", dec_v(0));
    push("ldi_ex", vec(3'd3, 0, 2'd0, 0, 3'd7, 1, 0, 2'd0, 0, 0, 0, 0));
    push("ldi_wb", vec(3'd5, 0, 2'd0, 0, 3'd0, 0, 1, 2'd2, 0, 0, 0, 0));
    ticks(4);
    instr_op = OP_BEQ;
    alu_zero = 1'b1;
    push("beq1_fetch", fetch_v(0)); push("beq1_dec", dec_v(0));
    push("beq1_ex", vec(3'd3, 1, 2'd1, 0, 3'd1, 0, 0, 2'd0, 0, 0, 0, 0));
    ticks(3);
    alu_zero = 1'b0;
    push("beq0_fetch", fetch_v(0)); push("beq0_dec", dec_v(0));
    push("beq0_ex", vec(3'd3, 0, 2'd0, 0, 3'd1, 0, 0, 2'd0, 0, 0, 0, 0));
    ticks(3);
    instr_op = OP_JMP;
    push("jmp_fetch", fetch_v(0));
    push("jmp_dec", vec(3'd2, 1, 2'd2, 0, 3'd0, 0, 0, 2'd0, 0, 0, 0, 0));
    ticks(2);
    instr_op = OP_ST;
    push("st_fetch", fetch_v(0)); push("st_dec", dec_v(0));
    push("st_ex", vec(3'd3, 0, 2'd0, 0, 3'd0, 1, 0, 2'd0, 0, 0, 0, 0));
    push("st_mem", vec(3'd4, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 1, 1, 0, 0));
    ticks(4);
    mem_ack = 1'b1;
    instr_op = 4'hD;
    push("ill_fetch", fetch_v(0));
    ticks(1);
    mem_ack = 1'b0;
    push("ill_dec", dec_v(0));
    ticks(1);
    instr_op = OP_NOP;
    push("nop_fetch_err", fetch_v(1)); push("nop_dec_err", dec_v(1));
    ticks(2);
    run = 1'b0;
    push("stop_idle0", idle_v(1)); push("stop_idle1", idle_v(1));
    ticks(2);
    #2 reset = 1'b0;
    push("rst_clears_err", idle_v(0));
    #1 chk();
    #2 reset = 1'b1;
    run = 1'b1;
    instr_op = OP_ST;
    push("sto_fetch", fetch_v(0)); push("sto_dec", dec_v(0));
    push("sto_ex", vec(3'd3, 0, 2'd0, 0, 3'd0, 1, 0, 2'd0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) push($sformatf("sto_mem%0d", i), vec(3'd4, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) push($sformatf("sto_halt%0d", i), vec(3'd6, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 0, 0, 1, 1));
    ticks(22);
    #2 reset = 1'b0;
    push("halt_rst", idle_v(0));
    #1 chk();
    #2 reset = 1'b1;
    instr_op = OP_LD;
    push("ldr_fetch", fetch_v(0)); push("ldr_dec", dec_v(0));
    push("ldr_ex", vec(3'd3, 0, 2'd0, 0, 3'd0, 1, 0, 2'd0, 0, 0, 0, 0));
    push("ldr_mem0", vec(3'd4, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 1, 0, 0, 0));
    push("ldr_mem1", vec(3'd4, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 1, 0, 0, 0));
    ticks(5);
    #2 reset = 1'b0;
    push("async_rst_mem", idle_v(0));
    #1 chk();
    mem_ack = 1'b1;
    instr_op = OP_NOP;
    #2 reset = 1'b1;
    push("late_ack_fetch", fetch_v(0)); push("late_ack_dec", dec_v(0));
    ticks(2);
    mem_ack = 1'b0;
    push("after_nop_fetch", fetch_v(0));
    ticks(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
